// File: rtl/ham_15_11_codec_arbiter_pkg.sv
// Shared constants for the Hamming(15,11) codec arbiter:
// FSM encoding, grant identifiers, parity and syndrome masks.
package ham_15_11_codec_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic GRANT_ENC = 1'b0;
  localparam logic GRANT_DEC = 1'b1;

  localparam logic OP_ENC = 1'b0;
  localparam logic OP_DEC = 1'b1;

  // data bits feeding p0..p3 (index k = parity bit k)
  localparam logic [3:0][10:0] P_MASK = {
    11'h7F0, 11'h78E, 11'h66D, 11'h55B
  };

  // codeword bits whose 1-based position has bit k set
  localparam logic [3:0][14:0] S_MASK = {
    15'h7F80, 15'h7878, 15'h6666, 15'h5555
  };

endpackage

// File: rtl/ham_15_11_codec.sv
// Combinational Hamming(15,11) encoder and single-error
// correcting decoder; syndrome/corr are forced to 0 for encodes.
module ham_15_11_codec
  import ham_15_11_codec_arbiter_pkg::*;
(
  input  logic        op,
  input  logic [10:0] d,
  input  logic [14:0] code,
  output logic [14:0] codeword,
  output logic [10:0] data,
  output logic [3:0]  syn,
  output logic        corr
);

  logic [3:0]  w_p;
  logic [3:0]  w_s;
  logic [14:0] w_flip;
  logic [14:0] w_fixed;

  // parity and syndrome reductions
  always_comb begin
    w_p = '0;
    w_s = '0;
    for (int k = 0; k < 4; k++) begin
      w_p[k] = ^(d & P_MASK[k]);
      w_s[k] = ^(code & S_MASK[k]);
    end
  end

  assign codeword = {d[10:4], w_p[3], d[3:1],
                     w_p[2], d[0], w_p[1], w_p[0]};

  assign w_flip  = (w_s != 4'd0) ?
                   (15'd1 << (w_s - 4'd1)) : 15'd0;
  assign w_fixed = code ^ w_flip;
  assign data    = {w_fixed[14:8], w_fixed[6:4], w_fixed[2]};

  assign syn  = (op == OP_DEC) ? w_s : 4'd0;
  assign corr = (op == OP_DEC) && (w_s != 4'd0);

endmodule

// File: rtl/ham_15_11_codec_arbiter.sv
// Round-robin arbiter time-sharing one Hamming(15,11) codec
// between encode and decode requesters, with correction counter.
module ham_15_11_codec_arbiter
  import ham_15_11_codec_arbiter_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enc_valid,
  output logic             enc_ready,
  input  logic [10:0]      enc_data,
  input  logic             dec_valid,
  output logic             dec_ready,
  input  logic [14:0]      dec_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [14:0]      out_data,
  output logic             out_is_dec,
  output logic [3:0]       out_syn,
  output logic             out_corr,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] corr_cnt
);

  logic [1:0]  r_state;
  logic        r_last_grant;
  logic        r_op;
  logic [14:0] r_operand;

  logic        w_idle;
  logic        w_pick_dec;
  logic        w_pick_enc;
  logic        w_accept;
  logic [14:0] w_cw;
  logic [10:0] w_data;
  logic [3:0]  w_syn;
  logic        w_corr;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_pick_dec = dec_valid &&
                      (!enc_valid || r_last_grant == GRANT_ENC);
  assign w_pick_enc = enc_valid && !w_pick_dec;
  assign enc_ready  = w_idle && w_pick_enc;
  assign dec_ready  = w_idle && w_pick_dec;
  assign w_accept   = enc_ready || dec_ready;

  ham_15_11_codec u_codec (
    .op       (r_op),
    .d        (r_operand[10:0]),
    .code     (r_operand),
    .codeword (w_cw),
    .data     (w_data),
    .syn      (w_syn),
    .corr     (w_corr)
  );

  // latch the granted operand and remember who won
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op         <= OP_ENC;
      r_operand    <= '0;
      r_last_grant <= GRANT_DEC;
    end else if (w_accept) begin
      r_op         <= w_pick_dec ? OP_DEC : OP_ENC;
      r_operand    <= w_pick_dec ? dec_code
                                 : {4'b0, enc_data};
      r_last_grant <= w_pick_dec ? GRANT_DEC : GRANT_ENC;
    end
  end

  // IDLE -> CALC -> HOLD sequencing and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_is_dec <= 1'b0;
      out_syn    <= '0;
      out_corr   <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) r_state <= ST_CALC;
        end
        ST_CALC: begin
          out_data   <= (r_op == OP_DEC) ?
                        {4'b0, w_data} : w_cw;
          out_is_dec <= r_op;
          out_syn    <= w_syn;
          out_corr   <= w_corr;
          out_valid  <= 1'b1;
          r_state    <= ST_HOLD;
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // saturating count of corrected decodes, clear wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt <= '0;
    end else if (clr_cnt) begin
      corr_cnt <= '0;
    end else if (r_state == ST_CALC && w_corr &&
                 !(&corr_cnt)) begin
      corr_cnt <= corr_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ham_15_11_codec_arbiter.sv
// Directed bench for ham_15_11_codec_arbiter: vector table
// plus hand-written arbitration, hold, counter and reset cases.
module tb_ham_15_11_codec_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enc_valid, enc_ready;
  logic [10:0] enc_data;
  logic        dec_valid, dec_ready;
  logic [14:0] dec_code;
  logic        out_valid, out_ready;
  logic [14:0] out_data;
  logic        out_is_dec;
  logic [3:0]  out_syn;
  logic        out_corr;
  logic        clr_cnt;
  logic [3:0]  corr_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ham_15_11_codec_arbiter #(.CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .enc_valid(enc_valid), .enc_ready(enc_ready),
    .enc_data(enc_data),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_code(dec_code),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_is_dec(out_is_dec),
    .out_syn(out_syn), .out_corr(out_corr),
    .clr_cnt(clr_cnt), .corr_cnt(corr_cnt)
  );

  typedef struct {
    logic        is_dec;
    logic [10:0] d;
    logic [14:0] code;
    logic [14:0] exp_data;
    logic [3:0]  exp_syn;
    logic        exp_corr;
  } vec_t;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // one full transaction; returns ready samples and result
  task automatic xact(input logic ev, input logic dv,
                      input logic [10:0] ed,
                      input logic [14:0] dc,
                      output logic ger, output logic gdr,
                      output logic [14:0] od,
                      output logic [3:0] os,
                      output logic oc, output logic oi);
    @(negedge clk);
    enc_valid = ev; dec_valid = dv;
    enc_data = ed; dec_code = dc;
    #1;
    ger = enc_ready; gdr = dec_ready;
    @(posedge clk);
    @(negedge clk);
    enc_valid = 1'b0; dec_valid = 1'b0;
    chk("lat_calc_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("lat_hold_valid", {31'd0, out_valid}, 32'd1);
    od = out_data; os = out_syn;
    oc = out_corr; oi = out_is_dec;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  vec_t        tbl [11];
  logic        ger, gdr, oc, oi;
  logic [14:0] od, held;
  logic [3:0]  os;
  int          exp_cnt;

  initial begin
    tbl[0]  = '{1'b0, 11'h001, 15'h0000, 15'h0007, 4'd0,  1'b0};
    tbl[1]  = '{1'b0, 11'h000, 15'h0000, 15'h0000, 4'd0,  1'b0};
    tbl[2]  = '{1'b0, 11'h7FF, 15'h0000, 15'h7FFF, 4'd0,  1'b0};
    tbl[3]  = '{1'b0, 11'h400, 15'h0000, 15'h408B, 4'd0,  1'b0};
    tbl[4]  = '{1'b0, 11'h002, 15'h0000, 15'h0019, 4'd0,  1'b0};
    tbl[5]  = '{1'b1, 11'h000, 15'h0207, 15'h0001, 4'd10, 1'b1};
    tbl[6]  = '{1'b1, 11'h000, 15'h7FFF, 15'h07FF, 4'd0,  1'b0};
    tbl[7]  = '{1'b1, 11'h000, 15'h7FFE, 15'h07FF, 4'd1,  1'b1};
    tbl[8]  = '{1'b1, 11'h000, 15'h008B, 15'h0400, 4'd15, 1'b1};
    tbl[9]  = '{1'b1, 11'h000, 15'h0004, 15'h0000, 4'd3,  1'b1};
    tbl[10] = '{1'b1, 11'h000, 15'h0019, 15'h0002, 4'd0,  1'b0};

    rst_n = 1'b0;
    enc_valid = 1'b0; dec_valid = 1'b0;
    enc_data = '0; dec_code = '0;
    out_ready = 1'b0; clr_cnt = 1'b0;
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {17'd0, out_data}, 32'd0);
    chk("rst_corr_cnt", {28'd0, corr_cnt}, 32'd0);
    chk("rst_readies", {30'd0, enc_ready, dec_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // tie: both valid every transaction, ENC first
    for (int i = 0; i < 4; i++) begin
      xact(1'b1, 1'b1, 11'h001, 15'h0000,
           ger, gdr, od, os, oc, oi);
      chk($sformatf("tie_grant%0d", i),
          {30'd0, ger, gdr},
          (i % 2 == 0) ? 32'd2 : 32'd1);
      chk($sformatf("tie_is_dec%0d", i),
          {31'd0, oi}, (i % 2 == 0) ? 32'd0 : 32'd1);
    end

    exp_cnt = 0;
    foreach (tbl[i]) begin
      xact(!tbl[i].is_dec, tbl[i].is_dec,
           tbl[i].d, tbl[i].code,
           ger, gdr, od, os, oc, oi);
      chk($sformatf("vec%0d_ready", i), {30'd0, ger, gdr},
          tbl[i].is_dec ? 32'd1 : 32'd2);
      chk($sformatf("vec%0d_data", i), {17'd0, od},
          {17'd0, tbl[i].exp_data});
      chk($sformatf("vec%0d_syn", i), {28'd0, os},
          {28'd0, tbl[i].exp_syn});
      chk($sformatf("vec%0d_corr_isdec", i),
          {30'd0, oc, oi},
          {30'd0, tbl[i].exp_corr, tbl[i].is_dec});
      if (tbl[i].exp_corr) exp_cnt++;
    end
    chk("cnt_after_table", {28'd0, corr_cnt}, exp_cnt);

    // hold: consumer stalls for 5 cycles
    @(negedge clk);
    enc_valid = 1'b1; enc_data = 11'h400;
    @(posedge clk);
    @(negedge clk);
    enc_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    held = out_data;
    chk("hold_first", {17'd0, held}, 32'h408B);
    enc_valid = 1'b1; dec_valid = 1'b1;
    dec_code = 15'h0000;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("hold_cyc%0d", i),
          {14'd0, out_data, out_valid,
           enc_ready, dec_ready},
          {14'd0, 15'h408B, 1'b1, 2'b00});
    end
    out_ready = 1'b1;
    #1;
    chk("hold_done_readies",
        {30'd0, enc_ready, dec_ready}, 32'd0);
    @(posedge clk);
    #1 out_ready = 1'b0;
    enc_valid = 1'b0; dec_valid = 1'b0;
    @(negedge clk);
    chk("hold_released", {31'd0, out_valid}, 32'd0);

    // clear beats an increment in the same cycle
    clr_cnt = 1'b1;
    xact(1'b0, 1'b1, 11'h000, 15'h0207,
         ger, gdr, od, os, oc, oi);
    chk("clr_vs_inc", {28'd0, corr_cnt}, 32'd0);
    clr_cnt = 1'b0;

    // saturation at all-ones
    for (int i = 0; i < 17; i++)
      xact(1'b0, 1'b1, 11'h000, 15'h7FFE,
           ger, gdr, od, os, oc, oi);
    chk("cnt_saturated", {28'd0, corr_cnt}, 32'hF);

    // async reset in the CALC cycle
    @(negedge clk);
    enc_valid = 1'b1; enc_data = 11'h7FF;
    @(posedge clk);
    @(negedge clk);
    enc_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("calc_rst_outs",
        {9'd0, out_data, out_valid, out_is_dec,
         out_syn, out_corr},
        32'd0);
    chk("calc_rst_cnt", {28'd0, corr_cnt}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    xact(1'b1, 1'b1, 11'h001, 15'h0207,
         ger, gdr, od, os, oc, oi);
    chk("post_rst_grant", {30'd0, ger, gdr}, 32'd2);
    chk("post_rst_data", {17'd0, od}, 32'h0007);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
